// File: rtl/console_buffer_if.sv
// Console buffer bus: core write side, flush request, downstream byte stream
// and status. The master modport is the side that drives the block (core and
// sink); the slave modport is the console_buffer itself.
interface console_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            console_we;
    logic [XLEN-1:0] console_wdata;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [LW-1:0]   level;
    logic            full;
    logic            empty;
    logic            overflow;
    logic [15:0]     overflow_count;

    modport master (
        output console_we, console_wdata, flush, out_ready,
        input  out_valid, out_data, level, full, empty, overflow, overflow_count
    );

    modport slave (
        input  console_we, console_wdata, flush, out_ready,
        output out_valid, out_data, level, full, empty, overflow, overflow_count
    );
endinterface

// File: rtl/console_buffer.sv
// Console output buffer: a first-word-fall-through byte FIFO between the core
// console write port and a ready/valid byte sink. In line mode bytes are held
// back until a terminator is queued, the FIFO fills, or a flush is requested.
// Bytes offered while no slot is available are dropped and counted.
module console_buffer #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 16,
    parameter int          LINE_MODE = 0,
    parameter logic [7:0]  NEWLINE   = 8'h0A
) (
    input  logic            clk,
    input  logic            reset,
    console_buffer_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    // Storage and state
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] nl_count_q, nl_count_d;
    logic          flush_pending_q, flush_pending_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   overflow_count_q, overflow_count_d;

    // Per-cycle decode
    logic       full;
    logic       empty;
    logic       out_valid;
    logic       push;
    logic       pop;
    logic       drop;
    logic       push_nl;
    logic       pop_nl;
    logic [7:0] head;
    logic [7:0] wbyte;

    // Status, release condition and handshake decode; outputs depend only on
    // registered state so nothing on the write side reaches them directly.
    always_comb begin
        wbyte = bus.console_wdata[7:0];
        head  = mem_q[rd_ptr_q];
        full  = (level_q == DEPTH_L);
        empty = (level_q == '0);

        if (LINE_MODE != 0) begin
            out_valid = !empty && ((nl_count_q != '0) || full || flush_pending_q);
        end else begin
            out_valid = !empty;
        end

        pop     = out_valid && bus.out_ready;
        // A full FIFO can still take a byte when the head leaves this cycle.
        push    = bus.console_we && (!full || pop);
        drop    = bus.console_we && !push;
        push_nl = push && (wbyte == NEWLINE);
        pop_nl  = pop && (head == NEWLINE);
    end

    // Next-state computation for pointers, occupancy and overflow bookkeeping.
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q;
        nl_count_d       = nl_count_q;
        flush_pending_d  = flush_pending_q;
        overflow_d       = overflow_q;
        overflow_count_d = overflow_count_q;

        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case ({push_nl, pop_nl})
            2'b10:   nl_count_d = nl_count_q + 1'b1;
            2'b01:   nl_count_d = nl_count_q - 1'b1;
            default: nl_count_d = nl_count_q;
        endcase

        // Flush only matters in line mode; a flush into an empty FIFO is a
        // no-op, and the request is retired once the FIFO has drained.
        if ((LINE_MODE != 0) && bus.flush && !empty) flush_pending_d = 1'b1;
        if (level_d == '0)                           flush_pending_d = 1'b0;

        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_count_q != 16'hFFFF) begin
                overflow_count_d = overflow_count_q + 16'd1;
            end
        end
    end

    // Control state register; reset overrides push, pop, flush and drops.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            nl_count_q       <= '0;
            flush_pending_q  <= 1'b0;
            overflow_q       <= 1'b0;
            overflow_count_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            nl_count_q       <= nl_count_d;
            flush_pending_q  <= flush_pending_d;
            overflow_q       <= overflow_d;
            overflow_count_q <= overflow_count_d;
        end
    end

    // Byte storage write.
    // NOTE: the array is deliberately not reset; stale entries are unreachable
    // once level and the pointers are cleared, and a plain RAM stays inferable.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= wbyte;
        end
    end

    assign bus.out_valid      = out_valid;
    assign bus.out_data       = empty ? 8'h00 : head;
    assign bus.level          = level_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.overflow       = overflow_q;
    assign bus.overflow_count = overflow_count_q;
endmodule

// File: tb/tb_console_buffer.sv
// Directed bench for console_buffer: one byte-mode instance (DEPTH=4) and one
// line-mode instance (DEPTH=8) sharing clock and reset. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_console_buffer;
    logic clk;
    logic reset;

    int n_cmp;
    int n_mis;

    console_buffer_if #(.XLEN(32), .DEPTH(4)) bif ();
    console_buffer_if #(.XLEN(32), .DEPTH(8)) lif ();

    console_buffer #(.XLEN(32), .DEPTH(4), .LINE_MODE(0), .NEWLINE(8'h0A)) u_byte (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    console_buffer #(.XLEN(32), .DEPTH(8), .LINE_MODE(1), .NEWLINE(8'h0A)) u_line (
        .clk   (clk),
        .reset (reset),
        .bus   (lif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] drain_exp [4];
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h07};
        n_cmp = 0;
        n_mis = 0;

        reset = 1'b1;
        bif.console_we = 1'b0; bif.console_wdata = '0; bif.flush = 1'b0; bif.out_ready = 1'b0;
        lif.console_we = 1'b0; lif.console_wdata = '0; lif.flush = 1'b0; lif.out_ready = 1'b0;
        tick();
        // Write during reset must be ignored and not counted.
        bif.console_we = 1'b1; bif.console_wdata = 32'h0000_0099;
        tick();
        bif.console_we = 1'b0;
        reset = 1'b0;

        // Reset state
        check("rst_valid",  {31'd0, bif.out_valid}, 32'd0);
        check("rst_data",   {24'd0, bif.out_data}, 32'd0);
        check("rst_level",  32'(bif.level), 32'd0);
        check("rst_empty",  {31'd0, bif.empty}, 32'd1);
        check("rst_full",   {31'd0, bif.full}, 32'd0);
        check("rst_ovf",    {31'd0, bif.overflow}, 32'd0);
        check("rst_ovfcnt", {16'd0, bif.overflow_count}, 32'd0);
        check("rst_l_valid", {31'd0, lif.out_valid}, 32'd0);
        check("rst_l_empty", {31'd0, lif.empty}, 32'd1);

        // Byte mode: "A","B" with sink ready
        bif.out_ready = 1'b1;
        bif.console_we = 1'b1; bif.console_wdata = 32'h41;
        check("ab_valid_pre", {31'd0, bif.out_valid}, 32'd0);
        tick();
        check("ab_valid_a", {31'd0, bif.out_valid}, 32'd1);
        check("ab_data_a",  {24'd0, bif.out_data}, 32'h41);
        bif.console_wdata = 32'h42;
        tick();
        bif.console_we = 1'b0;
        check("ab_valid_b", {31'd0, bif.out_valid}, 32'd1);
        check("ab_data_b",  {24'd0, bif.out_data}, 32'h42);
        check("ab_level_b", 32'(bif.level), 32'd1);
        tick();
        check("ab_empty",   {31'd0, bif.empty}, 32'd1);
        check("ab_valid_e", {31'd0, bif.out_valid}, 32'd0);
        check("ab_data_e",  {24'd0, bif.out_data}, 32'd0);

        // Byte mode: six pushes into a stalled DEPTH=4 FIFO
        bif.out_ready = 1'b0;
        bif.console_we = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bif.console_wdata = 32'(i);
            tick();
        end
        bif.console_we = 1'b0;
        check("ovf_level",  32'(bif.level), 32'd4);
        check("ovf_full",   {31'd0, bif.full}, 32'd1);
        check("ovf_flag",   {31'd0, bif.overflow}, 32'd1);
        check("ovf_count",  {16'd0, bif.overflow_count}, 32'd2);
        check("ovf_head",   {24'd0, bif.out_data}, 32'h01);

        // Full FIFO with simultaneous pop and push
        bif.out_ready = 1'b1;
        bif.console_we = 1'b1; bif.console_wdata = 32'h07;
        tick();
        bif.console_we = 1'b0;
        check("fpp_level", 32'(bif.level), 32'd4);
        check("fpp_count", {16'd0, bif.overflow_count}, 32'd2);
        // Drain across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), {24'd0, bif.out_data}, 32'(drain_exp[i]));
            tick();
        end
        check("drain_empty", {31'd0, bif.empty}, 32'd1);

        // Line mode: "h","i" held until newline
        lif.out_ready = 1'b1;
        lif.console_we = 1'b1; lif.console_wdata = 32'h68;
        tick();
        lif.console_wdata = 32'h69;
        tick();
        lif.console_we = 1'b0;
        check("ln_hold_valid", {31'd0, lif.out_valid}, 32'd0);
        check("ln_hold_level", 32'(lif.level), 32'd2);
        lif.console_we = 1'b1; lif.console_wdata = 32'h0A;
        tick();
        lif.console_we = 1'b0;
        check("ln_v0", {31'd0, lif.out_valid}, 32'd1);
        check("ln_d0", {24'd0, lif.out_data}, 32'h68);
        tick();
        check("ln_v1", {31'd0, lif.out_valid}, 32'd1);
        check("ln_d1", {24'd0, lif.out_data}, 32'h69);
        tick();
        check("ln_v2", {31'd0, lif.out_valid}, 32'd1);
        check("ln_d2", {24'd0, lif.out_data}, 32'h0A);
        tick();
        check("ln_v3",     {31'd0, lif.out_valid}, 32'd0);
        check("ln_empty3", {31'd0, lif.empty}, 32'd1);

        // Flush into an empty FIFO has no effect on later bytes
        lif.flush = 1'b1;
        tick();
        lif.flush = 1'b0;
        lif.console_we = 1'b1; lif.console_wdata = 32'h6F;
        tick();
        lif.console_wdata = 32'h6B;
        tick();
        lif.console_we = 1'b0;
        check("ok_hold_valid", {31'd0, lif.out_valid}, 32'd0);
        check("ok_hold_level", 32'(lif.level), 32'd2);
        lif.flush = 1'b1;
        tick();
        lif.flush = 1'b0;
        check("ok_v0", {31'd0, lif.out_valid}, 32'd1);
        check("ok_d0", {24'd0, lif.out_data}, 32'h6F);
        tick();
        check("ok_v1", {31'd0, lif.out_valid}, 32'd1);
        check("ok_d1", {24'd0, lif.out_data}, 32'h6B);
        tick();
        check("ok_empty", {31'd0, lif.empty}, 32'd1);
        // A new byte must be held again: the flush request has been retired
        lif.console_we = 1'b1; lif.console_wdata = 32'h78;
        tick();
        lif.console_we = 1'b0;
        check("fp_clear_valid", {31'd0, lif.out_valid}, 32'd0);
        check("fp_clear_level", 32'(lif.level), 32'd1);

        // Fill to DEPTH=8 without a newline: release on full
        lif.console_we = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lif.console_wdata = 32'h30 + 32'(i);
            tick();
        end
        lif.console_we = 1'b0;
        check("full_flag",  {31'd0, lif.full}, 32'd1);
        check("full_valid", {31'd0, lif.out_valid}, 32'd1);
        check("full_head",  {24'd0, lif.out_data}, 32'h78);
        tick();
        check("full_after_valid", {31'd0, lif.out_valid}, 32'd0);
        check("full_after_level", 32'(lif.level), 32'd7);
        check("full_after_head",  {24'd0, lif.out_data}, 32'h30);

        // Reset mid-transfer with a write pending
        bif.out_ready = 1'b0;
        bif.console_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.console_wdata = 32'h11 + 32'(i);
            tick();
        end
        check("mid_level", 32'(bif.level), 32'd3);
        bif.console_wdata = 32'h55;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bif.console_we = 1'b0;
        check("mid_rst_level",  32'(bif.level), 32'd0);
        check("mid_rst_valid",  {31'd0, bif.out_valid}, 32'd0);
        check("mid_rst_ovfcnt", {16'd0, bif.overflow_count}, 32'd0);
        check("mid_rst_ovf",    {31'd0, bif.overflow}, 32'd0);
        check("mid_rst_l_level", 32'(lif.level), 32'd0);
        bif.console_we = 1'b1; bif.console_wdata = 32'h5A;
        tick();
        bif.console_we = 1'b0;
        check("z_valid", {31'd0, bif.out_valid}, 32'd1);
        check("z_data",  {24'd0, bif.out_data}, 32'h5A);
        check("z_level", 32'(bif.level), 32'd1);
        bif.out_ready = 1'b1;
        tick();
        check("z_empty", {31'd0, bif.empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
